// File: rtl/priority_decoder_seq_if.sv
// Handshake and output bundle for priority_decoder_seq: the source drives
// code_i/valid_i, the decoder returns ready_o and the one-hot result lines.
interface priority_decoder_seq_if #(
    parameter int W = 2
);
    // Handshake: code_i is transferred on a rising edge where valid_i && ready_o;
    // valid_i while ready_o is low is ignored, and nothing is queued.
    logic [W-1:0]      code_i;
    logic              valid_i;
    logic              ready_o;
    logic [2**W-1:0]   y_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output code_i,
        output valid_i,
        input  ready_o,
        input  y_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  code_i,
        input  valid_i,
        output ready_o,
        output y_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/priority_decoder_seq.sv
// Sequential one-hot decoder: holds y_o for a window per accepted code, then a done pulse.
// Define PDEC_HOLD_EN for a HOLD-cycle window; otherwise the window is one cycle.
module priority_decoder_seq #(
    parameter int W    = 2,
    parameter int HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    priority_decoder_seq_if.slave bus,
    output logic [1:0]            o_dbg_state
);
    localparam int NY = 2**W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_code;
    logic         w_accept;
    logic         w_cnt_zero;

    if (HOLD < 1 || HOLD > 255) begin : g_hold_check
        $error("priority_decoder_seq: HOLD must be in 1..255");
    end

    assign w_accept = (r_state == S_IDLE) && bus.valid_i && rst_n;

`ifdef PDEC_HOLD_EN
    localparam int CW = $clog2(HOLD + 1);
    logic [CW-1:0] r_cnt;

    // Loaded with HOLD-1 on acceptance so DRIVE spans exactly HOLD cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CW'(HOLD - 1);
        end else if (r_state == S_DRIVE && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign w_cnt_zero = (r_cnt == '0);
`else
    assign w_cnt_zero = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_code <= '0;
        end else if (w_accept) begin
            r_code <= bus.code_i;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_next = S_DRIVE;
            S_DRIVE: if (w_cnt_zero) w_next = S_GAP;
            S_GAP:                   w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    // Moore outputs; ready_o also gated by rst_n so nothing is offered during reset.
    always_comb begin
        bus.ready_o = 1'b0;
        bus.y_o     = '0;
        bus.busy_o  = 1'b0;
        bus.done_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.ready_o = rst_n;
            end
            S_DRIVE: begin
                bus.y_o    = {{(NY-1){1'b0}}, 1'b1} << r_code;
                bus.busy_o = 1'b1;
            end
            S_GAP: begin
                bus.busy_o = 1'b1;
                bus.done_o = 1'b1;
            end
            default: begin
                bus.ready_o = 1'b0;
            end
        endcase
    end

    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_priority_decoder_seq.sv
// Bench for priority_decoder_seq: directed and random stimulus, occupancy model,
// expected one-hot codes queued at acceptance and checked by a negedge monitor.
module tb_priority_decoder_seq;
    localparam int W    = 2;
    localparam int HOLD = 4;
    localparam int NY   = 4;
`ifdef PDEC_HOLD_EN
    localparam int HOLD_EFF = HOLD;
`else
    localparam int HOLD_EFF = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    priority_decoder_seq_if #(.W(W)) bus();

    priority_decoder_seq #(.W(W), .HOLD(HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    logic [NY-1:0] exp_q[$];
    int  busy_left  = 0;
    int  accepts    = 0;
    bit  started    = 0;
    bit  reset_edge = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [W-1:0] c);
        rst_n       = r;
        bus.valid_i = v;
        bus.code_i  = c;
    endtask

    // Reference: a code is taken when the block has been free and out of reset;
    // it then stays occupied for the hold window plus the done cycle.
    task automatic step();
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            busy_left  = 0;
            exp_q.delete();
            reset_edge = 1;
        end else if (busy_left == 0 && bus.valid_i === 1'b1) begin
            exp_q.push_back(NY'(1) << bus.code_i);
            busy_left = HOLD_EFF + 1;
            accepts++;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        started = 1;
        #2;
    endtask

    task automatic wait_accept(input logic [W-1:0] c);
        int n;
        n = accepts;
        drive(1'b1, 1'b1, c);
        for (int t = 0; t < 40 && accepts == n; t++) step();
        if (accepts == n) check("accept_timeout", 32'd0, 32'd1);
    endtask

    logic [NY-1:0] cur;
    int            run_len = 0;

    always @(negedge clk) begin
        if (started) begin
            if (reset_edge) begin
                run_len    = 0;
                reset_edge = 0;
            end
            check("ready_o", {31'd0, bus.ready_o}, {31'd0, (rst_n === 1'b1 && busy_left == 0)});
            check("busy_o", {31'd0, bus.busy_o}, {31'd0, (busy_left > 0)});
            if (bus.y_o !== '0) begin
                if (run_len == 0) begin
                    if (exp_q.size() == 0) begin
                        cur = '0;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                check("y_o", {28'd0, bus.y_o}, {28'd0, cur});
                check("done_o_in_drive", {31'd0, bus.done_o}, 32'd0);
                run_len++;
            end else if (run_len > 0) begin
                check("hold_len", run_len, HOLD_EFF);
                check("done_o_pulse", {31'd0, bus.done_o}, 32'd1);
                run_len = 0;
            end else begin
                check("done_o_idle", {31'd0, bus.done_o}, 32'd0);
            end
        end
    end

    initial begin
        drive(1'b0, 1'b1, 2'b11);

        // Reset held with valid high: nothing may be accepted.
        repeat (2) step();

        // Single code.
        drive(1'b1, 1'b1, 2'b10);
        step();
        drive(1'b1, 1'b0, 2'b00);
        repeat (HOLD_EFF + 4) step();

        // Code changes while busy must be ignored; 11 taken on first idle cycle.
        drive(1'b1, 1'b1, 2'b01);
        step();
        drive(1'b1, 1'b1, 2'b11);
        repeat (HOLD_EFF + 3) step();
        drive(1'b1, 1'b0, 2'b00);
        repeat (HOLD_EFF + 3) step();

        // Back-to-back codes with valid held high.
        for (int k = 0; k < 4; k++) wait_accept(W'(k));
        drive(1'b1, 1'b0, 2'b00);
        repeat (HOLD_EFF + 4) step();

        // Reset during the second hold cycle.
        wait_accept(2'b01);
        drive(1'b1, 1'b0, 2'b00);
        step();
        drive(1'b0, 1'b0, 2'b00);
        step();
        drive(1'b1, 1'b0, 2'b00);
        repeat (3) step();

        // Random traffic with occasional resets.
        repeat (600) begin
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), W'($urandom_range(0, 3)));
            step();
        end

        drive(1'b1, 1'b0, 2'b00);
        repeat (HOLD_EFF + 4) step();
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_ready", {31'd0, bus.ready_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
